// File: rtl/data_memory_mmio_pkg.sv
// Shared types and constants for the mspu data-memory stage: access sizes,
// MMIO address defaults, status-word layout and the load formatter.
package mspu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10
    } mem_size_t;

    localparam logic [31:0] UART_TX_ADDR_DEF   = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR_DEF = 32'h1000_0004;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 8;

    // Size encoding 2'b11 falls through to a full word.
    function automatic logic [31:0] format_load(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sign);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        if (size == SZ_BYTE)
            res = {{24{sign & sh[7]}}, sh[7:0]};
        else if (size == SZ_HALF)
            res = {{16{sign & sh[15]}}, sh[15:0]};
        else
            res = sh;
        return res;
    endfunction

endpackage

// File: rtl/data_memory_mmio_if.sv
// UART transmit stream between the data-memory stage and the UART.
interface data_memory_mmio_if;
    // A byte transfers on every rising edge where uart_valid && uart_ready;
    // uart_data is held stable while uart_valid is high and uart_ready is low.
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       uart_ready;

    modport master (output uart_data, output uart_valid, input uart_ready);
    modport slave  (input uart_data, input uart_valid, output uart_ready);
endinterface

// File: rtl/simple_dualportram.sv
// Dual-port RAM: port A read/write with a read enable, port B write-only.
module simple_dualportram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             en_a,
    input  logic             we_a,
    input  logic [DEPTH-1:0] addr_a,
    input  logic [WIDTH-1:0] din_a,
    output logic [WIDTH-1:0] dout_a,
    input  logic             we_b,
    input  logic [DEPTH-1:0] addr_b,
    input  logic [WIDTH-1:0] din_b
);
    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (we_a)
            mem[addr_a] <= din_a;
        if (we_b)
            mem[addr_b] <= din_b;
        if (en_a)
            dout_a <= mem[addr_a];
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART; pointers carry one extra wrap bit.
module uart_tx_fifo #(
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic        push,
    output logic        full,
    output logic [7:0]  dout,
    output logic        valid,
    input  logic        ready,
    output logic [AW:0] count
);
    logic [7:0]  mem [2**AW];
    logic [AW:0] wptr, rptr;
    logic        do_push, do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign valid   = (wptr != rptr);
    assign count   = wptr - rptr;
    assign dout    = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = valid && ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + 1'b1;
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/data_memory_mmio.sv
// mspu data-memory stage: byte-lane RAM, sub-word loads, misalignment
// detection, UART TX FIFO behind MMIO and a deferrable loader write port.
module data_memory_mmio
    import mspu_mem_pkg::*;
#(
    parameter int          DEPTH          = 12,
    parameter int          FIFO_AW        = 3,
    parameter logic [31:0] UART_TX_ADDR   = UART_TX_ADDR_DEF,
    parameter logic [31:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [1:0]  bytes,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        mem_to_reg_in,
    input  logic [31:0] alu_result,
    input  logic [4:0]  rd_in,
    input  logic        reg_we_in,
    input  logic [31:0] addr_b,
    input  logic [31:0] din_b,
    input  logic        we_b,
    output logic [31:0] reg_wdata,
    output logic        reg_we_out,
    output logic [4:0]  reg_rd,
    output logic        misalign,
    output logic        stall_req,
    output logic        b_busy,
    data_memory_mmio_if.master uart
);
    localparam int RAW = DEPTH - 2;

    logic            is_byte, is_half, is_word;
    logic [1:0]      off;
    logic            is_tx, is_stat, is_ram, mis, active, core_ram_store;
    logic [RAW-1:0]  ram_idx;
    logic [3:0]      lane_we;
    logic [31:0]     lane_wdata, ram_word;
    logic            fifo_full, fifo_push;
    logic [FIFO_AW:0] fifo_count;
    logic [31:0]     stat_word;

    assign is_byte = (bytes == SZ_BYTE);
    assign is_half = (bytes == SZ_HALF);
    assign is_word = !is_byte && !is_half;
    assign off     = addr[1:0];
    assign ram_idx = addr[DEPTH-1:2];
    assign is_tx   = (addr == UART_TX_ADDR);
    assign is_stat = (addr == UART_STAT_ADDR);
    assign is_ram  = !is_tx && !is_stat;
    assign mis     = (we || re) && ((is_half && off[0]) || (is_word && (off != 2'b00)));
    assign active  = reset && run && !stall;

    assign core_ram_store = we && active && !mis && is_ram;
    assign fifo_push      = we && active && is_tx && !fifo_full;
    // Only full matters here; a same-cycle pop still holds the core one cycle.
    assign stall_req      = we && is_tx && fifo_full;

    assign lane_wdata = wdata << {off, 3'b000};

    always_comb begin
        lane_we = 4'b0000;
        if (core_ram_store) begin
            if (is_byte)
                lane_we = 4'b0001 << off;
            else if (is_half)
                lane_we = 4'b0011 << off;
            else
                lane_we = 4'b1111;
        end
    end

    // Loader port: deferred by one core RAM store, retired on port B.
    logic           b_pend;
    logic [RAW-1:0] b_addr_q;
    logic [31:0]    b_din_q;
    logic           b_we;
    logic [RAW-1:0] b_waddr;
    logic [31:0]    b_wdata;
    logic           unused_addr_b;

    assign b_busy        = b_pend;
    assign b_we          = reset && !core_ram_store && (b_pend || we_b);
    assign b_waddr       = b_pend ? b_addr_q : addr_b[DEPTH-1:2];
    assign b_wdata       = b_pend ? b_din_q : din_b;
    assign unused_addr_b = ^{addr_b[31:DEPTH], addr_b[1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            b_pend   <= 1'b0;
            b_addr_q <= '0;
            b_din_q  <= '0;
        end else if (b_pend) begin
            if (!core_ram_store)
                b_pend <= 1'b0;
        end else if (we_b && core_ram_store) begin
            b_pend   <= 1'b1;
            b_addr_q <= addr_b[DEPTH-1:2];
            b_din_q  <= din_b;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_lane
        simple_dualportram #(
            .WIDTH (8),
            .DEPTH (RAW)
        ) u_ram (
            .clk    (clk),
            .en_a   (!stall),
            .we_a   (lane_we[i]),
            .addr_a (ram_idx),
            .din_a  (lane_wdata[8*i +: 8]),
            .dout_a (ram_word[8*i +: 8]),
            .we_b   (b_we),
            .addr_b (b_waddr),
            .din_b  (b_wdata[8*i +: 8])
        );
    end

    uart_tx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (wdata[7:0]),
        .push  (fifo_push),
        .full  (fifo_full),
        .dout  (uart.uart_data),
        .valid (uart.uart_valid),
        .ready (uart.uart_ready),
        .count (fifo_count)
    );

    always_comb begin
        stat_word = '0;
        stat_word[STAT_EMPTY_BIT]         = !uart.uart_valid;
        stat_word[STAT_FULL_BIT]          = fifo_full;
        stat_word[STAT_COUNT_LSB +: 8]    = 8'(fifo_count);
    end

    // Writeback stage; the RAM read register above is its lane-data half.
    logic        m2r_q, sign_q, mis_q, tx_q, stat_q;
    logic [1:0]  off_q, size_q;
    logic [31:0] alu_q, stat_word_q, load_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_we_out  <= 1'b0;
            reg_rd      <= '0;
            misalign    <= 1'b0;
            m2r_q       <= 1'b0;
            sign_q      <= 1'b0;
            mis_q       <= 1'b0;
            tx_q        <= 1'b0;
            stat_q      <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            alu_q       <= '0;
            stat_word_q <= '0;
        end else if (!stall) begin
            reg_we_out  <= run && reg_we_in;
            reg_rd      <= rd_in;
            misalign    <= mis;
            m2r_q       <= mem_to_reg_in;
            sign_q      <= sign_ext;
            mis_q       <= mis;
            tx_q        <= is_tx;
            stat_q      <= is_stat;
            off_q       <= off;
            size_q      <= bytes;
            alu_q       <= alu_result;
            stat_word_q <= stat_word;
        end
    end

    always_comb begin
        load_val = format_load(ram_word, off_q, size_q, sign_q);
        if (mis_q || tx_q)
            load_val = '0;
        else if (stat_q)
            load_val = stat_word_q;
    end

    assign reg_wdata = m2r_q ? load_val : alu_q;
endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: directed scenarios plus randomized loads and
// stores checked against a byte-array memory model and a TX byte queue.
module tb_data_memory_mmio;
    localparam logic [31:0] TX = 32'h1000_0000;
    localparam logic [31:0] ST = 32'h1000_0004;
    localparam logic [1:0]  B_WORD = 2'b00;
    localparam logic [1:0]  B_BYTE = 2'b01;
    localparam logic [1:0]  B_HALF = 2'b10;

    logic        clk = 1'b0;
    logic        reset, run, stall, sign_ext, we, re, mem_to_reg_in, reg_we_in, we_b;
    logic [31:0] addr, wdata, alu_result, addr_b, din_b;
    logic [1:0]  bytes;
    logic [4:0]  rd_in, last_rd;
    logic [31:0] reg_wdata;
    logic        reg_we_out, misalign, stall_req, b_busy;
    logic [4:0]  reg_rd;

    int errors = 0;
    int checks = 0;
    logic [7:0] mdl [0:4095];
    logic [7:0] exp_q[$];

    data_memory_mmio_if u_if ();

    data_memory_mmio dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .stall         (stall),
        .addr          (addr),
        .bytes         (bytes),
        .sign_ext      (sign_ext),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .mem_to_reg_in (mem_to_reg_in),
        .alu_result    (alu_result),
        .rd_in         (rd_in),
        .reg_we_in     (reg_we_in),
        .addr_b        (addr_b),
        .din_b         (din_b),
        .we_b          (we_b),
        .reg_wdata     (reg_wdata),
        .reg_we_out    (reg_we_out),
        .reg_rd        (reg_rd),
        .misalign      (misalign),
        .stall_req     (stall_req),
        .b_busy        (b_busy),
        .uart          (u_if)
    );

    // clock/reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // loader protocol: no new loader write while one is pending
    always @(posedge clk) begin
        if (reset === 1'b1 && we_b === 1'b1 && b_busy === 1'b1) begin
            errors++;
            $display("FAIL loader_protocol: we_b=1 while b_busy=1");
        end
    end

    // reference model
    function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
        if (sz == B_BYTE) return 1'b0;
        if (sz == B_HALF) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic int size_n(input logic [1:0] sz);
        if (sz == B_BYTE) return 1;
        if (sz == B_HALF) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sg);
        logic [31:0] v;
        int n;
        if (is_mis(a, sz) || a == TX) return 32'h0;
        n = size_n(sz);
        v = 32'h0;
        for (int k = 0; k < n; k++)
            v = v | (32'(mdl[int'(a[11:0]) + k]) << (8 * k));
        if (sg && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        if (!is_mis(a, sz))
            for (int k = 0; k < size_n(sz); k++)
                mdl[int'(a[11:0]) + k] = wd[8*k +: 8];
    endtask

    task automatic model_word(input logic [31:0] a, input logic [31:0] wd);
        for (int k = 0; k < 4; k++)
            mdl[int'({a[11:2], 2'b00}) + k] = wd[8*k +: 8];
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [1:0] sz, input logic sg, input logic [31:0] wd);
        we = w; re = r; addr = a; bytes = sz; sign_ext = sg; wdata = wd;
        mem_to_reg_in = r; reg_we_in = 1'b1;
        rd_in = 5'($urandom_range(1, 31));
        last_rd = rd_in;
        alu_result = $urandom;
        tick();
        we = 1'b0; re = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (reg_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_wdata: got %h want 0", reg_wdata);
        end
        checks++;
        if (reg_rd !== 5'h0) begin
            errors++; $display("FAIL reset_rd: got %h want 0", reg_rd);
        end
        checks++;
        if ({reg_we_out, misalign, b_busy, u_if.uart_valid, stall_req} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: we_out/misalign/b_busy/valid/stall_req=%b want 00000",
                     {reg_we_out, misalign, b_busy, u_if.uart_valid, stall_req});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_subword_loads();
        access(1, 0, 32'h40, B_WORD, 0, 32'h8001_7F80);
        model_store(32'h40, B_WORD, 32'h8001_7F80);
        access(0, 1, 32'h40, B_BYTE, 1, 0);
        checks++;
        if (reg_wdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_signed: got %h want ffffff80", reg_wdata);
        end
        checks++;
        if (reg_we_out !== 1'b1 || reg_rd !== last_rd) begin
            errors++; $display("FAIL wb_ctrl: we_out=%b rd=%0d want 1 rd=%0d", reg_we_out, reg_rd, last_rd);
        end
        access(0, 1, 32'h41, B_BYTE, 0, 0);
        checks++;
        if (reg_wdata !== 32'h0000_007F) begin
            errors++; $display("FAIL lbu: got %h want 0000007f", reg_wdata);
        end
        access(0, 1, 32'h42, B_HALF, 1, 0);
        checks++;
        if (reg_wdata !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh_signed: got %h want ffff8001", reg_wdata);
        end
        access(0, 1, 32'h43, B_BYTE, 1, 0);
        checks++;
        if (reg_wdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_lane3: got %h want ffffff80", reg_wdata);
        end
    endtask

    task automatic test_misalign();
        access(1, 0, 32'h44, B_WORD, 0, 32'h1234_5678);
        model_store(32'h44, B_WORD, 32'h1234_5678);
        access(1, 0, 32'h45, B_WORD, 0, 32'hDEAD_BEEF);
        checks++;
        if (misalign !== 1'b1) begin
            errors++; $display("FAIL mis_store: misalign=%b want 1", misalign);
        end
        access(0, 1, 32'h44, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h1234_5678 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL mis_store_nowrite: got %h misalign=%b want 12345678 0", reg_wdata, misalign);
        end
        access(0, 1, 32'h45, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h0 || misalign !== 1'b1) begin
            errors++; $display("FAIL mis_load: got %h misalign=%b want 0 1", reg_wdata, misalign);
        end
        access(0, 1, 32'h43, B_HALF, 1, 0);
        checks++;
        if (reg_wdata !== 32'h0 || misalign !== 1'b1) begin
            errors++; $display("FAIL mis_half: got %h misalign=%b want 0 1", reg_wdata, misalign);
        end
    endtask

    task automatic test_fifo();
        int  drained;
        logic pending, push_now;
        u_if.uart_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            access(1, 0, TX, B_BYTE, 0, 32'(8'h41 + i));
            exp_q.push_back(8'(8'h41 + i));
        end
        access(0, 1, ST, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h0000_0802) begin
            errors++; $display("FAIL stat_full: got %h want 00000802", reg_wdata);
        end
        we = 1'b1; re = 1'b0; addr = TX; bytes = B_BYTE; wdata = 32'h49; mem_to_reg_in = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++; $display("FAIL stall_req_full: got %b want 1", stall_req);
        end
        tick();
        tick();
        checks++;
        if (stall_req !== 1'b1) begin
            errors++; $display("FAIL stall_req_hold: got %b want 1", stall_req);
        end
        u_if.uart_ready = 1'b1;
        #1;
        pending = 1'b1;
        drained = 0;
        for (int cyc = 0; cyc < 40 && (exp_q.size() > 0 || pending); cyc++) begin
            push_now = 1'b0;
            if (u_if.uart_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL drain_extra: unexpected byte %h", u_if.uart_data);
                end else begin
                    if (u_if.uart_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL drain_order: got %h want %h", u_if.uart_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    drained++;
                end
            end
            if (pending && !stall_req) begin
                exp_q.push_back(8'h49);
                pending = 1'b0;
                push_now = 1'b1;
            end
            tick();
            if (push_now) we = 1'b0;
        end
        we = 1'b0;
        checks++;
        if (drained != 9 || pending) begin
            errors++; $display("FAIL drain_count: got %0d pending=%b want 9 0", drained, pending);
        end
        access(0, 1, ST, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h0000_0001 || u_if.uart_valid !== 1'b0) begin
            errors++;
            $display("FAIL stat_empty: got %h valid=%b want 00000001 0", reg_wdata, u_if.uart_valid);
        end
        u_if.uart_ready = 1'b0;
    endtask

    task automatic test_loader_collision();
        we = 1'b1; re = 1'b0; addr = 32'h10; bytes = B_WORD; wdata = 32'h1111_1111;
        mem_to_reg_in = 1'b0;
        we_b = 1'b1; addr_b = 32'h20; din_b = 32'h2222_2222;
        tick();
        we = 1'b0; we_b = 1'b0;
        model_word(32'h10, 32'h1111_1111);
        model_word(32'h20, 32'h2222_2222);
        checks++;
        if (b_busy !== 1'b1) begin
            errors++; $display("FAIL b_busy_set: got %b want 1", b_busy);
        end
        tick();
        checks++;
        if (b_busy !== 1'b0) begin
            errors++; $display("FAIL b_busy_clear: got %b want 0", b_busy);
        end
        access(0, 1, 32'h20, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h2222_2222) begin
            errors++; $display("FAIL loader_data: got %h want 22222222", reg_wdata);
        end
        access(0, 1, 32'h10, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h1111_1111) begin
            errors++; $display("FAIL core_data: got %h want 11111111", reg_wdata);
        end
    endtask

    task automatic test_reset_mid();
        u_if.uart_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            access(1, 0, TX, B_BYTE, 0, 32'($urandom_range(0, 255)));
        end
        access(1, 0, 32'h80, B_WORD, 0, 32'hA5A5_A5A5);
        model_store(32'h80, B_WORD, 32'hA5A5_A5A5);
        we = 1'b1; addr = 32'h84; bytes = B_WORD; wdata = 32'h0BAD_F00D;
        we_b = 1'b1; addr_b = 32'h80; din_b = 32'h5A5A_5A5A;
        tick();
        we = 1'b0; we_b = 1'b0;
        model_store(32'h84, B_WORD, 32'h0BAD_F00D);
        checks++;
        if (b_busy !== 1'b1 || u_if.uart_valid !== 1'b1 || reg_we_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: b_busy=%b valid=%b we_out=%b want 1 1 1",
                     b_busy, u_if.uart_valid, reg_we_out);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (u_if.uart_valid !== 1'b0 || b_busy !== 1'b0 || reg_we_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b b_busy=%b we_out=%b want 0 0 0",
                     u_if.uart_valid, b_busy, reg_we_out);
        end
        reset = 1'b1;
        exp_q.delete();
        tick();
        access(0, 1, 32'h80, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== model_load(32'h80, B_WORD, 0)) begin
            errors++; $display("FAIL reset_discard: got %h want a5a5a5a5", reg_wdata);
        end
        access(0, 1, 32'h84, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL reset_core_store: got %h want 0badf00d", reg_wdata);
        end
    endtask

    task automatic test_run_stall();
        logic [4:0] exp_rd;
        access(1, 0, 32'h90, B_WORD, 0, 32'h1357_9BDF);
        model_store(32'h90, B_WORD, 32'h1357_9BDF);
        run = 1'b0;
        access(1, 0, TX, B_BYTE, 0, 32'h55);
        checks++;
        if (reg_we_out !== 1'b0 || u_if.uart_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_tx: we_out=%b valid=%b want 0 0", reg_we_out, u_if.uart_valid);
        end
        access(1, 0, 32'h90, B_WORD, 0, 32'hFFFF_FFFF);
        checks++;
        if (reg_we_out !== 1'b0) begin
            errors++; $display("FAIL run_store: we_out=%b want 0", reg_we_out);
        end
        run = 1'b1;
        access(0, 1, 32'h90, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h1357_9BDF || reg_we_out !== 1'b1 || u_if.uart_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_gate: got %h we_out=%b valid=%b want 13579bdf 1 0",
                     reg_wdata, reg_we_out, u_if.uart_valid);
        end
        exp_rd = last_rd;
        stall = 1'b1;
        access(1, 0, 32'h90, B_WORD, 0, 32'hFFFF_FFFF);
        access(0, 1, 32'h40, B_BYTE, 0, 0);
        checks++;
        if (reg_wdata !== 32'h1357_9BDF || reg_rd !== exp_rd) begin
            errors++;
            $display("FAIL stall_hold: got %h rd=%0d want 13579bdf rd=%0d", reg_wdata, reg_rd, exp_rd);
        end
        stall = 1'b0;
        access(0, 1, 32'h90, B_WORD, 0, 0);
        checks++;
        if (reg_wdata !== 32'h1357_9BDF) begin
            errors++; $display("FAIL stall_store: got %h want 13579bdf", reg_wdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, exp;
        logic [1:0]  sz;
        logic        sg;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            we_b = 1'b1; addr_b = 32'h100 + 32'(4 * i); din_b = wd;
            model_word(addr_b, wd);
            tick();
        end
        we_b = 1'b0;
        checks++;
        if (b_busy !== 1'b0) begin
            errors++; $display("FAIL loader_direct: b_busy=%b want 0", b_busy);
        end
        for (int i = 0; i < 150; i++) begin
            a  = 32'h100 + 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                access(1, 0, a, sz, sg, wd);
                model_store(a, sz, wd);
            end else begin
                exp = model_load(a, sz, sg);
                access(0, 1, a, sz, sg, 0);
                checks++;
                if (reg_wdata !== exp) begin
                    errors++;
                    $display("FAIL rand_load: addr=%h size=%0d sign=%b got %h want %h",
                             a, sz, sg, reg_wdata, exp);
                end
            end
            checks++;
            if (misalign !== is_mis(a, sz)) begin
                errors++;
                $display("FAIL rand_misalign: addr=%h size=%0d got %b want %b",
                         a, sz, misalign, is_mis(a, sz));
            end
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b1; stall = 1'b0;
        we = 1'b0; re = 1'b0; addr = '0; bytes = '0; sign_ext = 1'b0; wdata = '0;
        mem_to_reg_in = 1'b0; alu_result = '0; rd_in = '0; reg_we_in = 1'b0; last_rd = '0;
        we_b = 1'b0; addr_b = '0; din_b = '0;
        u_if.uart_ready = 1'b0;

        test_reset();
        test_subword_loads();
        test_misalign();
        test_fifo();
        test_loader_collision();
        test_reset_mid();
        test_run_stall();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_memory_mmio.md
# data_memory_mmio

Parametrised data-memory stage of the mspu core. It sits between execute and writeback and owns the byte-lane data RAM, a loader write port and a memory-mapped UART transmit path. It adds four things: signed and unsigned sub-word loads, misalignment detection, a buffered UART TX FIFO with a ready/valid drain and core back-pressure, and collision-safe arbitration for the loader port.

## Interface
Parameters:
- `DEPTH`, 12: byte-address bits of the RAM; the RAM holds 2^(DEPTH-2) words.
- `FIFO_AW`, 3: log2 of the UART TX FIFO depth, giving 8 entries.
- `UART_TX_ADDR`, 32'h1000_0000: store address that pushes a byte into the TX FIFO.
- `UART_STAT_ADDR`, 32'h1000_0004: read-only status word.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `run`  in  1  0 forces `reg_we_out`=0 and blocks core stores and FIFO pushes.
- `stall`  in  1  hold all writeback registers and block core stores and pushes.
- `addr`  in  32  core byte address.
- `bytes`  in  2  access size: 00 word, 01 byte, 10 half, 11 word.
- `sign_ext`  in  1  sign-extend sub-word loads.
- `wdata`  in  32  store data, least-significant-aligned.
- `we`  in  1  core store request.
- `re`  in  1  core load request; qualifies the misalignment check.
- `mem_to_reg_in`  in  1  select load data rather than `alu_result`.
- `alu_result`  in  32  pass-through writeback value.
- `rd_in`  in  5  destination register.
- `reg_we_in`  in  1  register write enable.
- `addr_b`, `din_b`, `we_b`  in  32/32/1  loader word write; `addr_b[1:0]` ignored.
- `reg_wdata`  out  32  writeback data.
- `reg_we_out`  out  1  writeback enable.
- `reg_rd`  out  5  writeback register.
- `misalign`  out  1  one-cycle pulse when an access faulted.
- `stall_req`  out  1  combinational; core must hold the current access.
- `b_busy`  out  1  a loader write is pending.
- `uart_data`  out  8  TX byte.
- `uart_valid`  out  1  `uart_data` is valid.
- `uart_ready`  in  1  UART accepts the byte.

## Operation
- **Region decode.** `addr == UART_TX_ADDR` is TX, `addr == UART_STAT_ADDR` is STAT, any other address is RAM; RAM is indexed by `addr[DEPTH-1:2]`.
- **Misalignment.** An access is misaligned if it is a half-word with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - Applies only when `we` or `re` is set.
  - A misaligned store writes nothing.
  - A misaligned load returns 0.
  - Either case raises `misalign` for one cycle.
- **Loads.** Lane data is shifted by `addr[1:0]`, masked to size, then zero-extended or sign-extended from bit 7 or bit 15 according to `sign_ext`.
  - A TX read returns 0.
  - A STAT read returns {16'h0, count[7:0], 6'h0, full, empty}.
- **RAM stores.** Per-lane write enables are derived from the size and `addr[1:0]`, exactly as for byte, half and word stores.
- **TX stores.** A TX store pushes `wdata[7:0]`.
  - If the FIFO is full, `stall_req`=1, nothing is pushed and the core holds; the push occurs in the first cycle with full=0.
  - `stall_req` is also asserted when a pop frees a slot in the same cycle; it is driven by full only.
- **FIFO drain.** `uart_valid` = !empty and `uart_data` = head entry. A pop occurs on `uart_valid && uart_ready`.
  - Pointers are `FIFO_AW`+1 bits and wrap naturally.
  - Push and pop in the same cycle leave the count unchanged.
- **Loader port.** Without a conflict, `we_b` writes all 4 lanes immediately.
  - If a core RAM store occurs in the same cycle, the core store wins. `addr_b`/`din_b` are latched, `b_busy`=1, and the latched write retires in the next cycle that has no core RAM store; `b_busy` clears at that retire edge.
  - Issuing `we_b` while `b_busy`=1 is a protocol violation; the bench asserts it never happens.

## Timing
- **Reset values.** `reg_wdata`=0, `reg_we_out`=0, `reg_rd`=0, `misalign`=0, `b_busy`=0, FIFO empty, hence `uart_valid`=0 and `stall_req`=0.
- **Reset priority.** Reset mid-operation discards FIFO contents and any pending loader write.
- **Load latency.** A request presented at edge N has its writeback outputs valid after edge N+1. RAM read is registered; formatting is combinational from the registered lane data and the registered offset, size and sign fields.
- **Store latency.** A RAM store is visible to a load issued the next cycle.
- **Stall and run.** `stall`=1 freezes `reg_*` and `misalign`; `run`=0 clears `reg_we_out` at the next edge.
- **FIFO timing.** A byte pushed at edge N appears on `uart_valid` after edge N; there is no bypass.

## Structure
- **Package `mspu_mem_pkg`.**
  - enum `mem_size_t` {SZ_WORD=2'b00, SZ_BYTE=2'b01, SZ_HALF=2'b10}.
  - Address localparams used as parameter defaults.
  - STAT bit-position constants.
- **Sub-module `uart_tx_fifo`.** Parameter `AW`. Push side `din`/`push`/`full`, pop side `dout`/`valid`/`ready`, plus `count`.
- **RAM.** 4 lane instances of the existing `simple_dualportram` (WIDTH 8, DEPTH `DEPTH`-2).

## Test plan
- **Byte store and signed load.** Store word 0x8001_7F80 at 0x40, then an lb at 0x40 with `sign_ext`=1 → 0xFFFF_FF80; lbu at 0x41 → 0x7F; lh at 0x42 with `sign_ext`=1 → 0xFFFF_8001.
- **Misaligned word store.** sw 0xDEAD_BEEF at 0x45 → `misalign` pulses, RAM unchanged; a following lw at 0x44 returns the old value, and an lw at 0x45 returns 0 with a `misalign` pulse.
- **FIFO full and drain.** With `uart_ready`=0, issue 9 TX stores of bytes 0x41..0x49 → after 8 pushes, STAT reads 0x0000_0802 and `stall_req` is held on the 9th store. Raise `uart_ready` → bytes drain in order 0x41..0x49, then STAT reads 0x0000_0001.
- **Loader collision.** Core sw 0x1111_1111 at 0x10 and loader 0x2222_2222 at 0x20 in the same cycle → `b_busy` high for 1 cycle, then an lw at 0x20 returns 0x2222_2222 and 0x10 returns 0x1111_1111.
- **Reset mid-operation.** Pull `reset` low with 3 bytes queued and a pending loader write → next cycle `uart_valid`=0, `b_busy`=0, `reg_we_out`=0, and the address targeted by the pending write is unchanged.
- **Run and stall gating.** With `run`=0, a TX store and a RAM store → no push, no RAM change, `reg_we_out`=0. With `stall`=1, `reg_wdata` and `reg_rd` keep their last values.
